// File: rtl/iq_pair_dispatcher.sv
// ---------------------------------------------------------------------------------------------
// iq_pair_dispatcher
//
// Moves I/Q sample pairs from the IQ read stage into two downstream channel FIFOs.
// One pair is consumed per handshake. Both words are written on the next cycle with
// identical strobes. Pairs are counted into fixed-length blocks, and block_done pulses
// on the last pair of each block.
//
// Optional feature (compile-time macro IQ_DISPATCH_STALL_CNT_EN):
//   adds a saturating 16-bit stall_count output. It counts WAIT cycles in which a pair
//   is available but at least one FIFO is full.
//
// Ports:
//   clock         in   system clock, rising edge
//   reset         in   asynchronous active-low reset
//   enable        in   run request, level sensitive
//   flush         in   synchronous clear of sample_count (and stall_count)
//   iq_avail      in   read stage holds a valid pair
//   i_in, q_in    in   I/Q words from read stage
//   iq_rd_en      out  consume pair from read stage (combinational)
//   i_full        in   I FIFO full
//   q_full        in   Q FIFO full
//   i_wr_en       out  I FIFO write strobe (registered)
//   q_wr_en       out  Q FIFO write strobe (registered)
//   i_dout        out  I word to FIFO (registered)
//   q_dout        out  Q word to FIFO (registered)
//   sample_count  out  pairs written in current block (registered)
//   block_done    out  one-cycle pulse on the last pair of a block (combinational)
//   busy          out  high in any state except IDLE (registered)
//   stall_count   out  saturating stall cycle counter (only with the macro defined)
// ---------------------------------------------------------------------------------------------
module iq_pair_dispatcher #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BLOCK_LEN  = 1024,
    parameter int unsigned CNT_WIDTH  = 10
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  flush,
    input  logic                  iq_avail,
    input  logic [DATA_WIDTH-1:0] i_in,
    input  logic [DATA_WIDTH-1:0] q_in,
    output logic                  iq_rd_en,
    input  logic                  i_full,
    input  logic                  q_full,
    output logic                  i_wr_en,
    output logic                  q_wr_en,
    output logic [DATA_WIDTH-1:0] i_dout,
    output logic [DATA_WIDTH-1:0] q_dout,
    output logic [CNT_WIDTH-1:0]  sample_count,
    output logic                  block_done,
    output logic                  busy
`ifdef IQ_DISPATCH_STALL_CNT_EN
    ,
    output logic [15:0]           stall_count
`endif
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWait  = 2'd1,
        StWrite = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LastCount = CNT_WIDTH'(BLOCK_LEN - 1);

    state_t                r_state;
    state_t                w_state_next;
    logic                  w_handshake;
    logic                  w_in_write;
    logic                  w_last;

    logic                  r_wr_en;
    logic                  r_busy;
    logic [DATA_WIDTH-1:0] r_i_dout;
    logic [DATA_WIDTH-1:0] r_q_dout;
    logic [CNT_WIDTH-1:0]  r_sample_count;

    // ---------------------------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------------------------
    // The FIFO full flags are sampled only here. This block is the only writer, so room seen
    // at the handshake is still there one cycle later in WRITE.
    always_comb begin
        w_state_next = r_state;
        w_handshake  = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (enable) begin
                    w_state_next = StWait;
                end
            end
            StWait: begin
                if (iq_avail && !i_full && !q_full) begin
                    w_handshake  = 1'b1;
                    w_state_next = StWrite;
                end else if (!enable) begin
                    w_state_next = StIdle;
                end
            end
            StWrite: begin
                // A pair in flight always completes; enable only picks where to go after.
                w_state_next = enable ? StWait : StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------------------------------------------------------------------------------
    // Datapath and counters
    // ---------------------------------------------------------------------------------------
    assign w_in_write = (r_state == StWrite);
    assign w_last     = (r_sample_count == LastCount);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_en        <= 1'b0;
            r_busy         <= 1'b0;
            r_i_dout       <= '0;
            r_q_dout       <= '0;
            r_sample_count <= '0;
        end else begin
            // The strobe is high exactly during the WRITE cycle that follows a handshake.
            r_wr_en <= w_handshake;
            r_busy  <= (w_state_next != StIdle);
            if (w_handshake) begin
                r_i_dout <= i_in;
                r_q_dout <= q_in;
            end
            // Flush wins over the WRITE increment; the in-flight write goes uncounted.
            if (flush) begin
                r_sample_count <= '0;
            end else if (w_in_write) begin
                r_sample_count <= w_last ? '0 : r_sample_count + 1'b1;
            end
        end
    end

`ifdef IQ_DISPATCH_STALL_CNT_EN
    logic [15:0] r_stall_count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_stall_count <= '0;
        end else if (flush) begin
            r_stall_count <= '0;
        end else if ((r_state == StWait) && iq_avail && (i_full || q_full) &&
                     (r_stall_count != 16'hFFFF)) begin
            r_stall_count <= r_stall_count + 16'd1;
        end
    end

    assign stall_count = r_stall_count;
`endif

    // ---------------------------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------------------------
    // The state register resets asynchronously to IDLE, so iq_rd_en is low during reset.
    assign iq_rd_en     = w_handshake;
    assign i_wr_en      = r_wr_en;
    assign q_wr_en      = r_wr_en;
    assign i_dout       = r_i_dout;
    assign q_dout       = r_q_dout;
    assign sample_count = r_sample_count;
    assign busy         = r_busy;
    // Decoded, not registered, so it lines up with the wr_en strobes; a flush suppresses it.
    assign block_done   = w_in_write && w_last && !flush;

endmodule

// File: doc/iq_pair_dispatcher.md
Name: iq_pair_dispatcher

Overview:
- Sequencer between the IQ read stage and the two downstream channel FIFOs (I and Q).
- Pulls one I/Q pair per handshake from the read stage and writes both words together. Writes happen only when both FIFOs have room.
- Counts pairs into fixed-length blocks and pulses block_done at each block boundary.
- enable starts/stops the stream; flush restarts block counting.

Parameters:
DATA_WIDTH, 32, width of each I and Q word
BLOCK_LEN, 1024, pairs per block; must be >= 2
CNT_WIDTH, 10, sample counter width; 2**CNT_WIDTH >= BLOCK_LEN required

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
enable  in  1  run request; level sensitive
flush  in  1  synchronous clear of sample_count; single-cycle pulse
iq_avail  in  1  read stage holds a valid pair
i_in  in  DATA_WIDTH  I word from read stage
q_in  in  DATA_WIDTH  Q word from read stage
iq_rd_en  out  1  consume pair from read stage (combinational)
i_full  in  1  I FIFO full
q_full  in  1  Q FIFO full
i_wr_en  out  1  I FIFO write strobe (registered)
q_wr_en  out  1  Q FIFO write strobe (registered)
i_dout  out  DATA_WIDTH  I word to FIFO
q_dout  out  DATA_WIDTH  Q word to FIFO
sample_count  out  CNT_WIDTH  pairs written in current block
block_done  out  1  one-cycle pulse on the last pair of a block
busy  out  1  high in any state except IDLE

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - i_dout, q_dout, sample_count = 0.
  - i_wr_en, q_wr_en, block_done = 0.
  - iq_rd_en=0 while reset is low.
  - Reset asserted mid-transfer abandons any captured pair with no FIFO write.
- States: IDLE, WAIT, WRITE.
- IDLE:
  - busy=0, iq_rd_en=0.
  - enable=1 -> WAIT next cycle.
- WAIT:
  - Handshake condition: iq_avail & ~i_full & ~q_full.
  - When the condition holds: iq_rd_en=1 that cycle, i_in/q_in captured into i_dout/q_dout, next state WRITE.
  - Otherwise: iq_rd_en=0, stay in WAIT, outputs hold.
  - enable=0 in WAIT with no handshake -> IDLE.
- WRITE (exactly one cycle):
  - i_wr_en=q_wr_en=1; the two strobes are always identical.
  - sample_count increments.
  - If sample_count==BLOCK_LEN-1: block_done=1 this cycle and sample_count wraps to 0.
  - Next state: WAIT if enable=1, else IDLE.
- Latency: handshake cycle N -> FIFO write at cycle N+1. Peak throughput is one pair per 2 cycles, which matches the read stage.
- Full flags:
  - Sampled only in WAIT. This block is the sole FIFO writer, so a not-full flag at handshake guarantees room at the WRITE cycle.
  - Full flags asserting during WRITE are ignored.
- enable deasserted:
  - During a handshake or WRITE, the pair in flight still completes; the block then stops in IDLE.
  - sample_count holds, so the block resumes from the same count on re-enable.
- flush=1:
  - sample_count -> 0 next edge and no block_done is generated; this takes priority over an increment in the same cycle.
  - A pair in flight still writes; the write is not counted.
  - State is unaffected.
- block_done is registered-free decode of the WRITE state plus the count compare. It is high exactly one cycle, coincident with the wr_en strobes.
- All outputs except iq_rd_en and block_done are registered.

Optional Feature:
Macro: IQ_DISPATCH_STALL_CNT_EN
- Defined:
  - Adds output stall_count [15:0].
  - Increments each cycle in WAIT with iq_avail=1 and (i_full|q_full)=1.
  - Saturates at 16'hFFFF.
  - Cleared by reset and by flush.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset then enable=1, iq_avail=1, i_in=32'h00000400, q_in=32'hFFFFFC00, FIFOs empty -> iq_rd_en pulses at cycle 1; i_wr_en/q_wr_en at cycle 2 with those values; sample_count=1.
- BLOCK_LEN=4, continuous pairs -> writes every 2 cycles; block_done high with the 4th write; sample_count sequence 1,2,3,0.
- q_full=1 for 5 cycles with iq_avail=1 -> no iq_rd_en and no writes; handshake on the first cycle q_full=0; with the macro defined, stall_count=5.
- enable dropped the same cycle as a handshake -> the write still occurs next cycle, then IDLE with busy=0 and sample_count held; re-enable continues the count.
- flush during WRITE at sample_count=2 -> write occurs, sample_count=0, no block_done.
- reset asserted in WRITE -> wr_en, sample_count, i_dout, q_dout all 0 immediately; state IDLE after release.
